// File: rtl/snitch_icache_refill_arbiter.sv
// snitch_icache_refill_arbiter: round-robin refill arbiter with outstanding-refill limit and response routing
module snitch_icache_refill_arbiter #(
  parameter int NR_PORTS      = 4,
  parameter int ADDR_WIDTH    = 48,
  parameter int LINE_WIDTH    = 128,
  parameter int PENDING_COUNT = 2,
  parameter int IW            = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]    in_req_addr_i,
  input  logic [NR_PORTS-1:0]                    in_req_valid_i,
  output logic [NR_PORTS-1:0]                    in_req_ready_o,
  output logic [LINE_WIDTH-1:0]                  in_rsp_data_o,
  output logic [NR_PORTS-1:0]                    in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]                    in_rsp_ready_i,
  output logic [ADDR_WIDTH-1:0]                  out_req_addr_o,
  output logic [IW-1:0]                          out_req_id_o,
  output logic                                   out_req_valid_o,
  input  logic                                   out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]                  out_rsp_data_i,
  input  logic [IW-1:0]                          out_rsp_id_i,
  input  logic                                   out_rsp_valid_i,
  output logic                                   out_rsp_ready_o,
  output logic [$clog2(PENDING_COUNT+1)-1:0]     pending_o,
  output logic                                   rsp_err_o
);
  localparam int PW = $clog2(PENDING_COUNT+1);

  logic [IW-1:0] r_ptr, r_lock_idx, w_rr_idx, w_k;
  logic          r_lock, r_err;
  logic [PW-1:0] r_pending;
  logic          w_full, w_req_hs, w_rsp_hs, w_id_ok, w_stall;

  // Round-robin search; scanning downward lets the nearest valid port at/after ptr win
  always_comb begin
    w_rr_idx = r_ptr;
    for (int i = NR_PORTS-1; i >= 0; i--)
      if (in_req_valid_i[IW'((int'(r_ptr) + i) % NR_PORTS)]) w_rr_idx = IW'((int'(r_ptr) + i) % NR_PORTS);
  end

  // A stalled grant stays locked so later requesters cannot preempt it
  assign w_k             = r_lock ? r_lock_idx : w_rr_idx;
  assign w_full          = r_pending == PW'(PENDING_COUNT);
  assign out_req_valid_o = rst_ni & ~w_full & in_req_valid_i[w_k];
  assign out_req_addr_o  = in_req_addr_i[w_k];
  assign out_req_id_o    = w_k;
  assign w_req_hs        = out_req_valid_o & out_req_ready_i;
  assign w_stall         = out_req_valid_o & ~out_req_ready_i;

  // Only the granted port sees the downstream ready
  always_comb begin
    in_req_ready_o      = '0;
    in_req_ready_o[w_k] = w_req_hs;
  end

  // Responses carrying an unknown ID are accepted and dropped
  assign w_id_ok         = int'(out_rsp_id_i) < NR_PORTS;
  assign out_rsp_ready_o = w_id_ok ? in_rsp_ready_i[out_rsp_id_i] : 1'b1;
  assign w_rsp_hs        = out_rsp_valid_i & out_rsp_ready_o;
  assign in_rsp_data_o   = out_rsp_data_i;
  assign pending_o       = r_pending;
  assign rsp_err_o       = r_err;

  // Demultiplex the response valid onto the port named by its ID
  always_comb begin
    in_rsp_valid_o = '0;
    for (int i = 0; i < NR_PORTS; i++) in_rsp_valid_o[i] = out_rsp_valid_i & (out_rsp_id_i == IW'(i));
  end

  // Pointer, lock, saturating pending counter and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_pending  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_req_hs) r_ptr <= (w_k == IW'(NR_PORTS-1)) ? '0 : w_k + 1'b1;
      r_lock <= w_stall;
      if (w_stall) r_lock_idx <= w_k;
      if (w_req_hs & ~w_rsp_hs) r_pending <= r_pending + 1'b1;
      else if (w_rsp_hs & ~w_req_hs & (r_pending != '0)) r_pending <= r_pending - 1'b1;
      if (w_rsp_hs & (~w_id_ok | (r_pending == '0))) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
// tb_snitch_icache_refill_arbiter: directed checks of arbitration, locking, pending limit and response routing
module tb_snitch_icache_refill_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0][47:0] a_addr;
  logic [3:0]       a_vld, a_rdy_o, a_rsp_vld_o, a_rsp_rdy;
  logic [127:0]     a_rsp_data_o, a_rsp_data;
  logic [47:0]      a_out_addr;
  logic [1:0]       a_out_id, a_rsp_id, a_pend;
  logic             a_out_vld, a_out_rdy, a_rsp_v, a_rsp_rdy_o, a_err;

  logic [2:0][47:0] b_addr;
  logic [2:0]       b_vld, b_rdy_o, b_rsp_vld_o, b_rsp_rdy;
  logic [127:0]     b_rsp_data_o, b_rsp_data;
  logic [47:0]      b_out_addr;
  logic [1:0]       b_out_id, b_rsp_id, b_pend;
  logic             b_out_vld, b_out_rdy, b_rsp_v, b_rsp_rdy_o, b_err;

  int n_cmp = 0;
  int n_err = 0;

  snitch_icache_refill_arbiter #(.NR_PORTS(4), .PENDING_COUNT(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_req_addr_i(a_addr), .in_req_valid_i(a_vld), .in_req_ready_o(a_rdy_o),
    .in_rsp_data_o(a_rsp_data_o), .in_rsp_valid_o(a_rsp_vld_o), .in_rsp_ready_i(a_rsp_rdy),
    .out_req_addr_o(a_out_addr), .out_req_id_o(a_out_id), .out_req_valid_o(a_out_vld), .out_req_ready_i(a_out_rdy),
    .out_rsp_data_i(a_rsp_data), .out_rsp_id_i(a_rsp_id), .out_rsp_valid_i(a_rsp_v), .out_rsp_ready_o(a_rsp_rdy_o),
    .pending_o(a_pend), .rsp_err_o(a_err));

  snitch_icache_refill_arbiter #(.NR_PORTS(3), .PENDING_COUNT(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_req_addr_i(b_addr), .in_req_valid_i(b_vld), .in_req_ready_o(b_rdy_o),
    .in_rsp_data_o(b_rsp_data_o), .in_rsp_valid_o(b_rsp_vld_o), .in_rsp_ready_i(b_rsp_rdy),
    .out_req_addr_o(b_out_addr), .out_req_id_o(b_out_id), .out_req_valid_o(b_out_vld), .out_req_ready_i(b_out_rdy),
    .out_rsp_data_i(b_rsp_data), .out_rsp_id_i(b_rsp_id), .out_rsp_valid_i(b_rsp_v), .out_rsp_ready_o(b_rsp_rdy_o),
    .pending_o(b_pend), .rsp_err_o(b_err));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) a_addr[i] = 48'h1000 + 48'(i);
    for (int i = 0; i < 3; i++) b_addr[i] = 48'h2000 + 48'(i);
    a_vld = 4'hF; a_out_rdy = 1'b1; a_rsp_v = 1'b0; a_rsp_id = '0; a_rsp_rdy = 4'hF; a_rsp_data = '0;
    b_vld = '0; b_out_rdy = 1'b0; b_rsp_v = 1'b0; b_rsp_id = '0; b_rsp_rdy = '0; b_rsp_data = '0;
    #1;
    chk("rst_pend", a_pend, 0);
    chk("rst_err", a_err, 0);
    chk("rst_oval", a_out_vld, 0);
    chk("rst_irdy", a_rdy_o, 0);
    repeat (2) step();
    rst_n = 1'b1; a_vld = '0;
    step();

    // round robin over all ports with one refill in flight
    a_vld = 4'hF; a_out_rdy = 1'b1; a_rsp_rdy = 4'hF;
    for (int c = 0; c < 5; c++) begin
      a_rsp_v = (c > 0); a_rsp_id = 2'(c - 1);
      #1;
      chk("rr_id", a_out_id, c % 4);
      chk("rr_addr", a_out_addr, 48'h1000 + c % 4);
      if (c > 0) chk("rr_pend", a_pend, 1);
      step();
    end
    a_vld = '0; a_rsp_v = 1'b1; a_rsp_id = 2'd0;
    step();
    a_rsp_v = 1'b0;
    #1 chk("rr_drain", a_pend, 0);

    // single grant to port 3 moves ptr back to 0
    a_vld = 4'b1000;
    step();
    a_vld = '0; a_rsp_v = 1'b1; a_rsp_id = 2'd3;
    step();
    a_rsp_v = 1'b0;

    // lock: port 2 stalled, port 0 arrives later but would win by ptr
    a_vld = 4'b0100; a_out_rdy = 1'b0;
    #1;
    chk("lk_id1", a_out_id, 2);
    chk("lk_oval", a_out_vld, 1);
    chk("lk_irdy", a_rdy_o, 0);
    step();
    a_vld = 4'b0101;
    #1 chk("lk_id2", a_out_id, 2);
    step();
    chk("lk_id3", a_out_id, 2);
    a_out_rdy = 1'b1;
    #1 chk("lk_hs_rdy", a_rdy_o, 4'b0100);
    step();
    a_vld = 4'b0001;
    #1;
    chk("lk_next_id", a_out_id, 0);
    chk("lk_next_rdy", a_rdy_o, 4'b0001);
    step();

    // pending limit
    chk("full_pend", a_pend, 2);
    chk("full_oval", a_out_vld, 0);
    chk("full_irdy", a_rdy_o, 0);
    a_rsp_v = 1'b1; a_rsp_id = 2'd2;
    #1;
    chk("full_same_cyc", a_out_vld, 0);
    chk("full_rsp_rdy", a_rsp_rdy_o, 1);
    step();
    a_rsp_v = 1'b0;
    #1;
    chk("unfull_pend", a_pend, 1);
    chk("unfull_oval", a_out_vld, 1);
    chk("unfull_id", a_out_id, 0);
    step();
    a_vld = '0;
    #1 chk("refull_pend", a_pend, 2);

    // response backpressure on port 3
    a_rsp_v = 1'b1; a_rsp_id = 2'd3; a_rsp_rdy = 4'b0111; a_rsp_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_vld", a_rsp_vld_o, 4'b1000);
      chk("bp_rdy", a_rsp_rdy_o, 0);
      chk("bp_pend", a_pend, 2);
      step();
    end
    a_rsp_rdy = 4'hF;
    #1;
    chk("bp_rel_rdy", a_rsp_rdy_o, 1);
    chk("bp_data", a_rsp_data_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
    step();
    a_rsp_v = 1'b0;
    #1 chk("bp_pend1", a_pend, 1);
    step();
    chk("bp_pend_hold", a_pend, 1);

    // underflow saturates and flags an error
    a_rsp_v = 1'b1; a_rsp_id = 2'd0;
    step();
    chk("uf_pend0", a_pend, 0);
    chk("uf_err0", a_err, 0);
    step();
    chk("uf_pend", a_pend, 0);
    chk("uf_err", a_err, 1);
    a_rsp_v = 1'b0;
    step();
    chk("uf_sticky", a_err, 1);

    // reset with refill in flight and port 1 locked
    a_vld = 4'b0001; a_out_rdy = 1'b1;
    step();
    a_vld = 4'hF; a_out_rdy = 1'b0;
    #1 chk("pre_rst_id", a_out_id, 1);
    step();
    chk("pre_rst_pend", a_pend, 1);
    rst_n = 1'b0; a_out_rdy = 1'b1;
    #1;
    chk("mid_rst_pend", a_pend, 0);
    chk("mid_rst_err", a_err, 0);
    chk("mid_rst_oval", a_out_vld, 0);
    chk("mid_rst_irdy", a_rdy_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_id", a_out_id, 0);
    chk("post_rst_oval", a_out_vld, 1);
    step();
    a_vld = '0;
    #1 chk("post_rst_pend", a_pend, 1);

    // three-port instance: out-of-range response ID
    b_vld = 3'b001; b_out_rdy = 1'b1;
    #1 chk("b_err_pre", b_err, 0);
    step();
    b_vld = '0;
    #1 chk("b_pend1", b_pend, 1);
    b_rsp_v = 1'b1; b_rsp_id = 2'd3; b_rsp_rdy = 3'b000;
    #1;
    chk("b_drop_rdy", b_rsp_rdy_o, 1);
    chk("b_drop_vld", b_rsp_vld_o, 0);
    step();
    b_rsp_v = 1'b0;
    #1;
    chk("b_err", b_err, 1);
    chk("b_pend0", b_pend, 0);
    repeat (2) step();
    chk("b_err_sticky", b_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
